// File: rtl/clkdiv_monitor.sv
// clkdiv_monitor: measures the period and high time of a divided clock
// (div_in) in clk cycles, locks after LOCK_COUNT consecutive matching periods
// and flags period/duty mismatches or a stalled div_in while locked.
module clkdiv_monitor #(
   parameter int CNT_W      = 8,
   parameter int LOCK_COUNT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             div_in,
   input  logic [CNT_W-1:0] expected_period,
   output logic             rise_pulse,
   output logic             fall_pulse,
   output logic [CNT_W-1:0] period_out,
   output logic             period_valid,
   output logic             locked,
   output logic             error,
   output logic [7:0]       err_count
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARM    = 2'd1,
      TRACK  = 2'd2,
      LOCKED = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [2:0]       LOCK_N  = 3'(LOCK_COUNT);

   // Saturating increment for the CNT_W-wide counters.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

   // Saturating increment for the 8-bit error counter.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   state_t           state;
   logic             prev;
   logic [CNT_W-1:0] per_cnt;
   logic [CNT_W-1:0] hi_cnt;
   logic [CNT_W-1:0] high_time;
   logic [2:0]       match_cnt;

   logic             rise;
   logic             fall;
   logic             timeout;
   logic             match;
   logic [CNT_W-1:0] period_meas;
   logic [CNT_W-1:0] half_exp;
   logic [2:0]       match_next;

   assign rise        = div_in & ~prev;
   assign fall        = ~div_in & prev;
   assign timeout     = (per_cnt == CNT_MAX);
   assign period_meas = sat_inc(per_cnt);
   assign half_exp    = expected_period >> 1;
   // Odd expected periods cannot have an exact 50% duty, so only the period is compared.
   assign match       = (period_meas == expected_period) &&
                        (expected_period[0] || (high_time == half_exp));
   assign match_next  = match_cnt + 3'd1;

   // Edge detection, period/high-time measurement and lock FSM with registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         prev         <= 1'b0;
         per_cnt      <= '0;
         hi_cnt       <= '0;
         high_time    <= '0;
         match_cnt    <= 3'd0;
         rise_pulse   <= 1'b0;
         fall_pulse   <= 1'b0;
         period_out   <= '0;
         period_valid <= 1'b0;
         locked       <= 1'b0;
         error        <= 1'b0;
         err_count    <= 8'd0;
      end else begin
         prev         <= div_in;
         rise_pulse   <= 1'b0;
         fall_pulse   <= 1'b0;
         period_valid <= 1'b0;
         error        <= 1'b0;
         if (!enable) begin
            // Disable wins over any edge, match or timeout seen this cycle.
            state     <= IDLE;
            per_cnt   <= '0;
            hi_cnt    <= '0;
            match_cnt <= 3'd0;
            locked    <= 1'b0;
         end else begin
            if (state == IDLE) begin
               per_cnt   <= '0;
               hi_cnt    <= '0;
               match_cnt <= 3'd0;
            end else begin
               rise_pulse <= rise;
               fall_pulse <= fall;
               per_cnt    <= rise ? '0 : sat_inc(per_cnt);
               if (rise)
                  hi_cnt <= CNT_W'(1);
               else if (div_in)
                  hi_cnt <= sat_inc(hi_cnt);
               if (fall)
                  high_time <= hi_cnt;
            end
            case (state)
               IDLE: begin
                  state <= ARM;
               end
               ARM: begin
                  // The first rise only starts a period; nothing is measured yet.
                  if (rise)
                     state <= TRACK;
               end
               TRACK: begin
                  if (timeout) begin
                     state     <= ARM;
                     match_cnt <= 3'd0;
                  end else if (rise) begin
                     period_valid <= 1'b1;
                     period_out   <= period_meas;
                     if (match) begin
                        match_cnt <= match_next;
                        if (match_next >= LOCK_N) begin
                           state  <= LOCKED;
                           locked <= 1'b1;
                        end
                     end else begin
                        match_cnt <= 3'd0;
                     end
                  end
               end
               LOCKED: begin
                  if (timeout) begin
                     state     <= ARM;
                     locked    <= 1'b0;
                     error     <= 1'b1;
                     err_count <= sat_inc8(err_count);
                     match_cnt <= 3'd0;
                  end else if (rise) begin
                     period_valid <= 1'b1;
                     period_out   <= period_meas;
                     if (!match) begin
                        state     <= TRACK;
                        locked    <= 1'b0;
                        error     <= 1'b1;
                        err_count <= sat_inc8(err_count);
                        match_cnt <= 3'd0;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_clkdiv_monitor.sv
// tb_clkdiv_monitor: directed scenarios for clkdiv_monitor with
// hand-computed expectations (CNT_W=8, LOCK_COUNT=4).
module tb_clkdiv_monitor;

   logic       clk;
   logic       reset;
   logic       enable;
   logic       div_in;
   logic [7:0] expected_period;
   logic       rise_pulse;
   logic       fall_pulse;
   logic [7:0] period_out;
   logic       period_valid;
   logic       locked;
   logic       error;
   logic [7:0] err_count;

   int checks;
   int failures;

   // Observation accumulators filled while stepping the clock.
   int         pv_cnt;
   int         per_bad;
   int         err_seen;
   int         lock_at_pv;
   logic       lk_prev;
   logic [7:0] want_per;

   clkdiv_monitor #(.CNT_W(8), .LOCK_COUNT(4)) dut (
      .clk             (clk),
      .reset           (reset),
      .enable          (enable),
      .div_in          (div_in),
      .expected_period (expected_period),
      .rise_pulse      (rise_pulse),
      .fall_pulse      (fall_pulse),
      .period_out      (period_out),
      .period_valid    (period_valid),
      .locked          (locked),
      .error           (error),
      .err_count       (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end

   task automatic clear_stats();
      pv_cnt     = 0;
      per_bad    = 0;
      err_seen   = 0;
      lock_at_pv = -1;
      lk_prev    = locked;
   endtask

   // Drive div_in, clock once, sample 1 time unit after the edge.
   task automatic step(input logic d);
      div_in = d;
      @(posedge clk);
      #1;
      if (period_valid) begin
         pv_cnt++;
         if (period_out !== want_per) per_bad++;
      end
      if (error) err_seen++;
      if (locked && !lk_prev) lock_at_pv = period_valid ? pv_cnt : -100;
      lk_prev = locked;
   endtask

   task automatic gen_period(input int hi, input int lo);
      repeat (hi) step(1'b1);
      repeat (lo) step(1'b0);
   endtask

   task automatic restart(input logic [7:0] exp_p);
      enable = 1'b0;
      step(1'b0);
      expected_period = exp_p;
      want_per = exp_p;
      enable = 1'b1;
      step(1'b0);
      clear_stats();
   endtask

   task automatic test_reset();
      #1;
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL rst_locked got=%0d want=0", locked); end
      checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL rst_errcnt got=%0d want=0", err_count); end
      checks++; if (period_out !== 8'd0) begin failures++; $display("FAIL rst_period got=%0d want=0", period_out); end
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      step(1'b0);
      step(1'b1);
      checks++; if (rise_pulse !== 1'b0) begin failures++; $display("FAIL idle_rise got=%0d want=0", rise_pulse); end
      checks++; if (period_valid !== 1'b0) begin failures++; $display("FAIL idle_pv got=%0d want=0", period_valid); end
   endtask

   task automatic test_lock_div2();
      restart(8'd2);
      step(1'b1);
      checks++; if (rise_pulse !== 1'b1) begin failures++; $display("FAIL d2_rise got=%0d want=1", rise_pulse); end
      checks++; if (period_valid !== 1'b0) begin failures++; $display("FAIL d2_arm_pv got=%0d want=0", period_valid); end
      step(1'b0);
      checks++; if (fall_pulse !== 1'b1) begin failures++; $display("FAIL d2_fall got=%0d want=1", fall_pulse); end
      checks++; if (rise_pulse !== 1'b0) begin failures++; $display("FAIL d2_rise_low got=%0d want=0", rise_pulse); end
      repeat (7) gen_period(1, 1);
      checks++; if (pv_cnt !== 7) begin failures++; $display("FAIL d2_pv_cnt got=%0d want=7", pv_cnt); end
      checks++; if (per_bad !== 0) begin failures++; $display("FAIL d2_period got=%0d bad want=0 bad", per_bad); end
      checks++; if (lock_at_pv !== 4) begin failures++; $display("FAIL d2_lock_at got=%0d want=4", lock_at_pv); end
      checks++; if (err_seen !== 0) begin failures++; $display("FAIL d2_error got=%0d want=0", err_seen); end
      checks++; if (locked !== 1'b1) begin failures++; $display("FAIL d2_locked got=%0d want=1", locked); end
   endtask

   task automatic test_duty_mismatch();
      restart(8'd8);
      repeat (6) gen_period(3, 5);
      checks++; if (pv_cnt !== 5) begin failures++; $display("FAIL duty_pv_cnt got=%0d want=5", pv_cnt); end
      checks++; if (per_bad !== 0) begin failures++; $display("FAIL duty_period got=%0d bad want=0 bad", per_bad); end
      checks++; if (lock_at_pv !== -1) begin failures++; $display("FAIL duty_lock got=%0d want=-1", lock_at_pv); end
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL duty_locked got=%0d want=0", locked); end
      checks++; if (err_seen !== 0) begin failures++; $display("FAIL duty_error got=%0d want=0", err_seen); end
   endtask

   task automatic test_period_error();
      restart(8'd8);
      repeat (5) gen_period(4, 4);
      checks++; if (lock_at_pv !== 4) begin failures++; $display("FAIL perr_lock_at got=%0d want=4", lock_at_pv); end
      checks++; if (locked !== 1'b1) begin failures++; $display("FAIL perr_locked got=%0d want=1", locked); end
      gen_period(4, 6);
      step(1'b1);
      checks++; if (error !== 1'b1) begin failures++; $display("FAIL perr_error got=%0d want=1", error); end
      checks++; if (period_valid !== 1'b1) begin failures++; $display("FAIL perr_pv got=%0d want=1", period_valid); end
      checks++; if (period_out !== 8'd10) begin failures++; $display("FAIL perr_period got=%0d want=10", period_out); end
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL perr_unlock got=%0d want=0", locked); end
      checks++; if (err_count !== 8'd1) begin failures++; $display("FAIL perr_errcnt got=%0d want=1", err_count); end
      step(1'b1);
      checks++; if (error !== 1'b0) begin failures++; $display("FAIL perr_pulse_len got=%0d want=0", error); end
      step(1'b1);
      step(1'b1);
      repeat (4) step(1'b0);
      clear_stats();
      repeat (4) gen_period(4, 4);
      checks++; if (lock_at_pv !== 4) begin failures++; $display("FAIL perr_relock_at got=%0d want=4", lock_at_pv); end
      checks++; if (locked !== 1'b1) begin failures++; $display("FAIL perr_relocked got=%0d want=1", locked); end
      checks++; if (err_seen !== 0) begin failures++; $display("FAIL perr_extra_err got=%0d want=0", err_seen); end
   endtask

   // Continues from LOCKED at expected=8, 7 edges after the last rise.
   task automatic test_timeout();
      int  n;
      bit  hit;
      hit = 0;
      n = 0;
      for (int i = 1; i <= 400; i++) begin
         step(1'b0);
         if (error) begin
            n = i;
            hit = 1;
            break;
         end
      end
      checks++; if (!hit) begin failures++; $display("FAIL tmo_seen got=none want=error"); end
      checks++; if (n !== 249) begin failures++; $display("FAIL tmo_cycle got=%0d want=249", n); end
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL tmo_locked got=%0d want=0", locked); end
      checks++; if (err_count !== 8'd2) begin failures++; $display("FAIL tmo_errcnt got=%0d want=2", err_count); end
      step(1'b1);
      checks++; if (period_valid !== 1'b0) begin failures++; $display("FAIL tmo_arm_pv got=%0d want=0", period_valid); end
      checks++; if (rise_pulse !== 1'b1) begin failures++; $display("FAIL tmo_arm_rise got=%0d want=1", rise_pulse); end
      step(1'b0);
      step(1'b1);
      checks++; if (period_valid !== 1'b1) begin failures++; $display("FAIL tmo_track_pv got=%0d want=1", period_valid); end
      checks++; if (error !== 1'b0) begin failures++; $display("FAIL tmo_track_err got=%0d want=0", error); end
   endtask

   task automatic test_odd_expected();
      restart(8'd3);
      repeat (5) gen_period(1, 2);
      checks++; if (lock_at_pv !== 4) begin failures++; $display("FAIL odd_lock_at got=%0d want=4", lock_at_pv); end
      checks++; if (per_bad !== 0) begin failures++; $display("FAIL odd_period got=%0d bad want=0 bad", per_bad); end
      checks++; if (locked !== 1'b1) begin failures++; $display("FAIL odd_locked got=%0d want=1", locked); end
   endtask

   task automatic test_low_expected();
      restart(8'd1);
      want_per = 8'd2;
      repeat (10) gen_period(1, 1);
      checks++; if (pv_cnt !== 9) begin failures++; $display("FAIL low_pv_cnt got=%0d want=9", pv_cnt); end
      checks++; if (per_bad !== 0) begin failures++; $display("FAIL low_period got=%0d bad want=0 bad", per_bad); end
      checks++; if (lock_at_pv !== -1) begin failures++; $display("FAIL low_lock got=%0d want=-1", lock_at_pv); end
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL low_locked got=%0d want=0", locked); end
   endtask

   task automatic test_async_reset();
      restart(8'd8);
      repeat (5) gen_period(4, 4);
      gen_period(4, 6);
      gen_period(4, 4);
      repeat (4) gen_period(4, 4);
      checks++; if (locked !== 1'b1) begin failures++; $display("FAIL ar_pre_locked got=%0d want=1", locked); end
      checks++; if (err_count !== 8'd3) begin failures++; $display("FAIL ar_pre_errcnt got=%0d want=3", err_count); end
      #3;
      reset = 1'b1;
      #1;
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL ar_locked got=%0d want=0", locked); end
      checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL ar_errcnt got=%0d want=0", err_count); end
      checks++; if (period_out !== 8'd0) begin failures++; $display("FAIL ar_period got=%0d want=0", period_out); end
      checks++; if ({rise_pulse, fall_pulse, period_valid, error} !== 4'b0000) begin
         failures++; $display("FAIL ar_pulses got=%b want=0000", {rise_pulse, fall_pulse, period_valid, error});
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      step(1'b0);
      checks++; if (error !== 1'b0) begin failures++; $display("FAIL ar_rel_err got=%0d want=0", error); end
      step(1'b1);
      checks++; if (rise_pulse !== 1'b1) begin failures++; $display("FAIL ar_rel_rise got=%0d want=1", rise_pulse); end
      checks++; if (period_valid !== 1'b0) begin failures++; $display("FAIL ar_rel_pv got=%0d want=0", period_valid); end
   endtask

   task automatic test_enable_drop();
      restart(8'd8);
      repeat (5) gen_period(4, 4);
      gen_period(4, 6);
      gen_period(4, 4);
      repeat (4) gen_period(4, 4);
      step(1'b0);
      checks++; if (locked !== 1'b1) begin failures++; $display("FAIL en_pre_locked got=%0d want=1", locked); end
      checks++; if (err_count !== 8'd1) begin failures++; $display("FAIL en_pre_errcnt got=%0d want=1", err_count); end
      enable = 1'b0;
      step(1'b1);
      checks++; if (period_valid !== 1'b0) begin failures++; $display("FAIL en_pv got=%0d want=0", period_valid); end
      checks++; if (error !== 1'b0) begin failures++; $display("FAIL en_err got=%0d want=0", error); end
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL en_locked got=%0d want=0", locked); end
      checks++; if (err_count !== 8'd1) begin failures++; $display("FAIL en_errcnt got=%0d want=1", err_count); end
      step(1'b0);
      step(1'b1);
      checks++; if (rise_pulse !== 1'b0) begin failures++; $display("FAIL en_idle_rise got=%0d want=0", rise_pulse); end
      checks++; if (err_count !== 8'd1) begin failures++; $display("FAIL en_hold_errcnt got=%0d want=1", err_count); end
   endtask

   task automatic test_saturation();
      restart(8'd2);
      step(1'b1);
      step(1'b0);
      repeat (4) gen_period(1, 1);
      checks++; if (locked !== 1'b1) begin failures++; $display("FAIL sat_pre_locked got=%0d want=1", locked); end
      clear_stats();
      repeat (254) begin
         gen_period(1, 2);
         step(1'b1);
         step(1'b0);
         repeat (4) gen_period(1, 1);
      end
      checks++; if (err_count !== 8'd255) begin failures++; $display("FAIL sat_reach got=%0d want=255", err_count); end
      repeat (2) begin
         gen_period(1, 2);
         step(1'b1);
         step(1'b0);
         repeat (4) gen_period(1, 1);
      end
      checks++; if (err_count !== 8'd255) begin failures++; $display("FAIL sat_hold got=%0d want=255", err_count); end
      checks++; if (err_seen !== 256) begin failures++; $display("FAIL sat_pulses got=%0d want=256", err_seen); end
      checks++; if (locked !== 1'b1) begin failures++; $display("FAIL sat_locked got=%0d want=1", locked); end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      reset = 1'b1;
      enable = 1'b0;
      div_in = 1'b0;
      expected_period = 8'd0;
      want_per = 8'd0;
      pv_cnt = 0;
      per_bad = 0;
      err_seen = 0;
      lock_at_pv = -1;
      lk_prev = 1'b0;
      test_reset();
      test_lock_div2();
      test_duty_mismatch();
      test_period_error();
      test_timeout();
      test_odd_expected();
      test_low_expected();
      test_async_reset();
      test_enable_drop();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
